// File: rtl/conv_stream_pkg.sv
// rtl/conv_stream_pkg.sv - shared types and constants for the convolution stream ports
package conv_stream_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int NUM_BANKS  = 2;

    typedef logic [WORD_WIDTH-1:0] word_t;
    typedef logic                  bank_sel_t;

endpackage

// File: rtl/x_frame_bank.sv
// rtl/x_frame_bank.sv - two-bank LENX x WIDTH frame store, one write port, one async read port
module x_frame_bank
    import conv_stream_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LENX  = 8,
    parameter int ADDRX = 3
) (
    input  logic             clk,
    input  logic             we,
    input  bank_sel_t        wr_bank,
    input  logic [ADDRX-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  bank_sel_t        rd_bank,
    input  logic [ADDRX-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // Contents need no reset: a bank is only read after its full flag is set.
    logic [WIDTH-1:0] mem [NUM_BANKS][LENX];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/conv_x_transmitter.sv
// rtl/conv_x_transmitter.sv - ping-pong framed sender for the convolution engine x-sample port
module conv_x_transmitter
    import conv_stream_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LENX  = 8,
    parameter int ADDRX = 3,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ld_valid,
    output logic             ld_ready,
    output logic [WIDTH-1:0] m_data_out_x,
    output logic             m_valid_x,
    input  logic             m_ready_x,
    output logic             m_last_x,
    output logic             frame_sent,
    output logic [CNTW-1:0]  frame_count,
    output logic             busy
);

    localparam logic [ADDRX-1:0] LAST_PTR = ADDRX'(LENX - 1);

    logic [ADDRX-1:0]     ld_ptr;
    logic [ADDRX-1:0]     tx_ptr;
    bank_sel_t            ld_bank;
    bank_sel_t            tx_bank;
    logic [NUM_BANKS-1:0] full;
    logic [NUM_BANKS-1:0] full_next;
    logic [WIDTH-1:0]     rd_data;
    logic                 ld_fire;
    logic                 ld_wrap;
    logic                 tx_load;
    logic                 tx_wrap;

    assign ld_ready = !full[ld_bank];
    assign ld_fire  = ld_valid && ld_ready;
    assign ld_wrap  = ld_fire && (ld_ptr == LAST_PTR);
    assign tx_load  = full[tx_bank] && (!m_valid_x || m_ready_x);
    assign tx_wrap  = tx_load && (tx_ptr == LAST_PTR);

    // Set and clear can only collide on the same bank if it were both empty and full,
    // so applying them in sequence is safe.
    always_comb begin
        full_next = full;
        if (ld_wrap) full_next[ld_bank] = 1'b1;
        if (tx_wrap) full_next[tx_bank] = 1'b0;
    end

    x_frame_bank #(
        .WIDTH (WIDTH),
        .LENX  (LENX),
        .ADDRX (ADDRX)
    ) u_bank (
        .clk     (clk),
        .we      (ld_fire),
        .wr_bank (ld_bank),
        .wr_addr (ld_ptr),
        .wr_data (ld_data),
        .rd_bank (tx_bank),
        .rd_addr (tx_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_ptr       <= '0;
            ld_bank      <= 1'b0;
            tx_ptr       <= '0;
            tx_bank      <= 1'b0;
            full         <= '0;
            m_data_out_x <= '0;
            m_valid_x    <= 1'b0;
            m_last_x     <= 1'b0;
            frame_sent   <= 1'b0;
            frame_count  <= '0;
        end else begin
            full <= full_next;
            if (ld_fire) begin
                ld_ptr <= ld_wrap ? '0 : ld_ptr + ADDRX'(1);
                if (ld_wrap) ld_bank <= ~ld_bank;
            end
            if (tx_load) begin
                m_data_out_x <= rd_data;
                m_valid_x    <= 1'b1;
                m_last_x     <= (tx_ptr == LAST_PTR);
                tx_ptr       <= tx_wrap ? '0 : tx_ptr + ADDRX'(1);
                if (tx_wrap) tx_bank <= ~tx_bank;
            end else if (m_ready_x) begin
                m_valid_x <= 1'b0;
                m_last_x  <= 1'b0;
            end
            frame_sent <= m_valid_x && m_ready_x && m_last_x;
            if (m_valid_x && m_ready_x && m_last_x) begin
                frame_count <= frame_count + CNTW'(1);
            end
        end
    end

    assign busy = (|full) | m_valid_x | (ld_ptr != '0);

endmodule

// File: tb/tb_conv_x_transmitter.sv
// tb/tb_conv_x_transmitter.sv - table plus scoreboard bench for conv_x_transmitter
module tb_conv_x_transmitter;
    import conv_stream_pkg::*;

    localparam int LENX = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ld_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [15:0] m_data_out_x;
    logic        m_valid_x;
    logic        m_ready_x;
    logic        m_last_x;
    logic        frame_sent;
    logic [7:0]  frame_count;
    logic        busy;

    conv_x_transmitter #(.WIDTH(16), .LENX(LENX), .ADDRX(3), .CNTW(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .ld_data      (ld_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .m_data_out_x (m_data_out_x),
        .m_valid_x    (m_valid_x),
        .m_ready_x    (m_ready_x),
        .m_last_x     (m_last_x),
        .frame_sent   (frame_sent),
        .frame_count  (frame_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        word_t data;
        logic  last;
    } sb_t;

    typedef struct {
        logic        ld_valid;
        logic [15:0] ld_data;
        logic        m_ready;
        logic        exp_ld_ready;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic        exp_last;
        logic        exp_sent;
        logic [7:0]  exp_count;
    } vec_t;

    sb_t   sb[$];
    int    checks = 0;
    int    failures = 0;
    int    ld_idx = 0;
    int    out_words = 0;
    int    sent_pulses = 0;
    int    ready_mode = 1;
    logic  toggle = 1'b0;
    logic  sent_pending = 1'b0;
    logic  hold_pending = 1'b0;
    logic [15:0] hold_data = '0;
    logic  hold_last = 1'b0;
    logic [7:0] exp_count = '0;
    logic  ld_ready_s = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        ld_idx       = 0;
        exp_count    = '0;
        sent_pending = 1'b0;
        hold_pending = 1'b0;
    endtask

    // Sampled on the falling edge: everything seen here is what the next rising edge acts on.
    task automatic monitor();
        sb_t e;
        if (sent_pending) exp_count = exp_count + 8'd1;
        check("frame_sent", frame_sent, sent_pending);
        check("frame_count", frame_count, exp_count);
        if (frame_sent) sent_pulses++;
        if (hold_pending) begin
            check("hold_valid", m_valid_x, 1'b1);
            check("hold_data", m_data_out_x, hold_data);
            check("hold_last", m_last_x, hold_last);
        end
        hold_pending = m_valid_x && !m_ready_x;
        hold_data    = m_data_out_x;
        hold_last    = m_last_x;
        sent_pending = m_valid_x && m_ready_x && m_last_x;
        ld_ready_s   = ld_ready;
        if (ld_valid && ld_ready) begin
            e.data = ld_data;
            e.last = (ld_idx == LENX - 1);
            sb.push_back(e);
            ld_idx = (ld_idx + 1) % LENX;
        end
        if (m_valid_x && m_ready_x) begin
            out_words++;
            if (sb.size() == 0) begin
                check("unexpected_word", m_data_out_x, 32'hdead);
            end else begin
                e = sb.pop_front();
                check("out_data", m_data_out_x, e.data);
                check("out_last", m_last_x, e.last);
            end
        end
    endtask

    task automatic cycle();
        toggle = ~toggle;
        case (ready_mode)
            0: m_ready_x = 1'b0;
            1: m_ready_x = 1'b1;
            2: m_ready_x = toggle;
            3: m_ready_x = 1'($urandom_range(0, 1));
            default: ;
        endcase
        @(negedge clk);
        if (reset) monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input int n, input int base, output int stalls);
        int k = 0;
        int budget = n * 8 + 100;
        stalls = 0;
        while (k < n && budget > 0) begin
            ld_valid = 1'b1;
            ld_data  = 16'(base + k);
            cycle();
            if (ld_ready_s) k++;
            else stalls++;
            budget--;
        end
        ld_valid = 1'b0;
        check("load_timeout", k, n);
    endtask

    task automatic drain();
        int budget = 400;
        while (sb.size() > 0 && budget > 0) begin
            cycle();
            budget--;
        end
        check("drain_timeout", sb.size(), 0);
        cycle();
        cycle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_model();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    vec_t vt[17];
    int   stalls;
    int   base_words;
    int   base_pulses;
    int   budget;

    initial begin
        reset     = 1'b0;
        ld_data   = '0;
        ld_valid  = 1'b0;
        m_ready_x = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_valid", m_valid_x, 1'b0);
        check("rst_data", m_data_out_x, 16'h0);
        check("rst_last", m_last_x, 1'b0);
        check("rst_sent", frame_sent, 1'b0);
        check("rst_count", frame_count, 8'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_ld_ready", ld_ready, 1'b1);
        reset = 1'b1;

        // Single frame 1..8 with the sink always ready; one row per rising edge.
        for (int i = 0; i < 17; i++) begin
            vt[i].ld_valid     = (i < 8);
            vt[i].ld_data      = (i < 8) ? 16'(i + 1) : 16'h0;
            vt[i].m_ready      = 1'b1;
            vt[i].exp_ld_ready = 1'b1;
            vt[i].exp_valid    = (i >= 8 && i <= 15);
            vt[i].exp_data     = (i < 8) ? 16'h0 : (i <= 15) ? 16'(i - 7) : 16'd8;
            vt[i].exp_last     = (i == 15);
            vt[i].exp_sent     = (i == 16);
            vt[i].exp_count    = (i == 16) ? 8'd1 : 8'd0;
        end
        ready_mode = 4;
        for (int i = 0; i < 17; i++) begin
            ld_valid  = vt[i].ld_valid;
            ld_data   = vt[i].ld_data;
            m_ready_x = vt[i].m_ready;
            cycle();
            check("t1_ld_ready", ld_ready, vt[i].exp_ld_ready);
            check("t1_valid", m_valid_x, vt[i].exp_valid);
            check("t1_data", m_data_out_x, vt[i].exp_data);
            check("t1_last", m_last_x, vt[i].exp_last);
            check("t1_sent", frame_sent, vt[i].exp_sent);
            check("t1_count", frame_count, vt[i].exp_count);
        end
        ld_valid = 1'b0;
        cycle();

        // Two frames stacked up against a stalled sink, then released.
        ready_mode = 0;
        load_words(16, 1, stalls);
        check("t2_full_ld_ready", ld_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = 16'd99;
            cycle();
            check("t2_ignored_ld_ready", ld_ready, 1'b0);
        end
        ld_valid = 1'b0;
        check("t2_stalled_valid", m_valid_x, 1'b1);
        ready_mode = 1;
        base_words = out_words;
        for (int i = 0; i < 16; i++) cycle();
        check("t2_no_gap", out_words - base_words, 16);
        cycle();
        check("t2_count", frame_count, 8'd3);
        check("t2_sb_empty", sb.size(), 0);

        // Alternating backpressure.
        ready_mode = 2;
        load_words(8, 16'h100, stalls);
        drain();

        // Third frame loaded while the second is on the wire.
        ready_mode = 1;
        load_words(24, 16'h200, stalls);
        check("t4_ld_stalls", stalls, 0);
        drain();
        check("t4_count", frame_count, 8'd7);

        // Asynchronous reset in the middle of a frame.
        ready_mode = 1;
        base_words = out_words;
        ld_valid = 1'b1;
        budget = 100;
        while (out_words - base_words < 4 && budget > 0) begin
            ld_data = 16'(ld_idx + 1);
            if (ld_idx == LENX - 1) begin
                cycle();
                ld_valid = 1'b0;
            end else begin
                cycle();
            end
            budget--;
        end
        ld_valid = 1'b0;
        check("t5_wait_timeout", out_words - base_words, 4);
        #2;
        reset = 1'b0;
        clear_model();
        #1;
        check("t5_valid", m_valid_x, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_count", frame_count, 8'd0);
        check("t5_last", m_last_x, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        load_words(8, 20, stalls);
        drain();
        check("t5_fresh_count", frame_count, 8'd1);

        // 256 frames under random backpressure: counter wraps back to zero.
        do_reset();
        ready_mode = 3;
        base_pulses = sent_pulses;
        load_words(256 * LENX, 16'h1000, stalls);
        ready_mode = 1;
        drain();
        check("t6_pulses", sent_pulses - base_pulses, 256);
        check("t6_wrap_count", frame_count, 8'd0);
        check("t6_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
